// File: rtl/fetch_pkg.sv
// Shared constants, FSM state type and PC field helpers for the instruction fetch reader.
package fetch_pkg;
    localparam int LINES   = 32;
    localparam int SLOTS   = 8;
    localparam int SLOT_W  = 9;
    localparam int ADDR_W  = 5;
    localparam int PC_W    = 8;
    localparam int SLOT_IW = PC_W - ADDR_W;
    localparam logic [SLOT_W-1:0] HALT_OP = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2
    } fetch_state_e;

    function automatic logic [ADDR_W-1:0] pc_line(input logic [PC_W-1:0] pc);
        return pc[PC_W-1:SLOT_IW];
    endfunction

    function automatic logic [SLOT_IW-1:0] pc_slot(input logic [PC_W-1:0] pc);
        return pc[SLOT_IW-1:0];
    endfunction
endpackage

// File: rtl/fetch_slot_mux.sv
// Picks one instruction out of a buffered SRAM line; slot 0 sits in the least significant bits.
module fetch_slot_mux
    import fetch_pkg::*;
(
    input  logic [SLOTS*SLOT_W-1:0] line_buf,
    input  logic [SLOT_IW-1:0]      slot,
    output logic [SLOT_W-1:0]       instr
);
    always_comb begin
        instr = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (slot == SLOT_IW'(i)) begin
                instr = line_buf[i*SLOT_W +: SLOT_W];
            end
        end
    end
endmodule

// File: rtl/sram_fetch_reader.sv
// Read-side client of the instruction SRAM: loads one line, then streams its slots
// to decode over valid/ready until HALT, a redirect or reset.
//
//   state | meaning
//   IDLE  | waiting for start; no SRAM access, nothing offered
//   LOAD  | SRAM enabled at pc line; line captured at the clock edge
//   ISSUE | instruction at pc offered to decode from the line buffer
module sram_fetch_reader
    import fetch_pkg::*;
(
    input  logic                     clka,
    input  logic                     rst,
    input  logic                     start,
    input  logic [PC_W-1:0]          start_pc,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic                     sram_ena,
    output logic                     sram_wea,
    output logic [ADDR_W-1:0]        sram_addra,
    input  logic [SLOTS*SLOT_W-1:0]  sram_douta,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [SLOT_W-1:0]        instr_data,
    output logic [PC_W-1:0]          instr_pc,
    output logic                     busy
);
    fetch_state_e              state_q, state_d;
    logic [PC_W-1:0]           pc_q, pc_d;
    logic [SLOTS*SLOT_W-1:0]   line_q;
    logic [ADDR_W-1:0]         addr_q;
    logic                      line_ld;
    logic [SLOT_W-1:0]         slot_instr;

    fetch_slot_mux u_slot_mux (
        .line_buf (line_q),
        .slot     (pc_slot(pc_q)),
        .instr    (slot_instr)
    );

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            line_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (line_ld) begin
                line_q <= sram_douta;
            end
            if (state_q == LOAD) begin
                addr_q <= pc_line(pc_q);
            end
        end
    end

    // Redirect outranks both accept and HALT; an accept in the same cycle still counts as delivered.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        line_ld = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    pc_d    = start_pc;
                end
            end
            LOAD: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else begin
                    line_ld = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = LOAD;
                end else if (instr_ready) begin
                    if (slot_instr == HALT_OP) begin
                        state_d = IDLE;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                        if (pc_slot(pc_q) == SLOT_IW'(SLOTS-1)) begin
                            state_d = LOAD;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address follows pc only while loading and otherwise keeps the last line fetched.
    always_comb begin
        sram_ena    = (state_q == LOAD);
        sram_wea    = 1'b0;
        sram_addra  = (state_q == LOAD) ? pc_line(pc_q) : addr_q;
        instr_valid = (state_q == ISSUE);
        instr_data  = (state_q == ISSUE) ? slot_instr : '0;
        instr_pc    = (state_q == ISSUE) ? pc_q : '0;
        busy        = (state_q != IDLE);
    end
endmodule

// File: tb/tb_sram_fetch_reader.sv
// Scoreboard bench for sram_fetch_reader: a PC-walk model fills the expected queue,
// a negedge monitor pops and compares every accepted instruction.
module tb_sram_fetch_reader;
    import fetch_pkg::*;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic                    rst, start, redirect, instr_ready;
    logic [PC_W-1:0]         start_pc, redirect_pc;
    logic                    sram_ena, sram_wea, instr_valid, busy;
    logic [ADDR_W-1:0]       sram_addra;
    logic [SLOTS*SLOT_W-1:0] sram_douta;
    logic [SLOT_W-1:0]       instr_data;
    logic [PC_W-1:0]         instr_pc;

    logic [SLOTS*SLOT_W-1:0] mem [LINES];
    assign sram_douta = mem[sram_addra];

    sram_fetch_reader dut (
        .clka        (clka),
        .rst         (rst),
        .start       (start),
        .start_pc    (start_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .sram_ena    (sram_ena),
        .sram_wea    (sram_wea),
        .sram_addra  (sram_addra),
        .sram_douta  (sram_douta),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .busy        (busy)
    );

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [SLOT_W-1:0] data;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_busy = 0;
    int   busy_cyc = 0;
    logic hold_chk = 1'b0;
    logic [SLOT_W-1:0] hold_d;
    logic [PC_W-1:0]   hold_p;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [SLOT_W-1:0] mem_slot(input logic [PC_W-1:0] p);
        logic [SLOTS*SLOT_W-1:0] w;
        w = mem[p[7:3]];
        return w[int'(p[2:0])*SLOT_W +: SLOT_W];
    endfunction

    task automatic set_slot(input int l, input int s, input logic [SLOT_W-1:0] v);
        mem[l][s*SLOT_W +: SLOT_W] = v;
    endtask

    // Walk the program from p0 until HALT; each new line costs one extra load cycle.
    task automatic build(input logic [PC_W-1:0] p0);
        logic [PC_W-1:0]   p;
        logic [SLOT_W-1:0] d;
        exp_t              e;
        expq.delete();
        exp_busy = 0;
        p = p0;
        for (int i = 0; i < 256; i++) begin
            d = mem_slot(p);
            e.pc = p;
            e.data = d;
            expq.push_back(e);
            exp_busy += (i == 0 || p[2:0] == 3'd0) ? 2 : 1;
            if (d == HALT_OP) break;
            p = p + 8'd1;
        end
    endtask

    always @(negedge clka) begin
        exp_t e;
        if (busy) busy_cyc++;
        if (rst) begin
            if (sram_ena) begin
                check("ena_vs_valid", 32'(instr_valid), 32'd0);
                if (expq.size() == 0) check("unexpected_load", 32'd1, 32'd0);
                else check("load_addr", 32'(sram_addra), 32'(expq[0].pc[7:3]));
            end
            if (hold_chk && instr_valid) begin
                check("hold_data", 32'(instr_data), 32'(hold_d));
                check("hold_pc", 32'(instr_pc), 32'(hold_p));
            end
            if (instr_valid && instr_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_instr", 32'(instr_pc), 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    check("instr_pc", 32'(instr_pc), 32'(e.pc));
                    check("instr_data", 32'(instr_data), 32'(e.data));
                end
            end
            hold_chk = instr_valid && !instr_ready;
            hold_d   = instr_data;
            hold_p   = instr_pc;
        end else begin
            hold_chk = 1'b0;
        end
    end

    task automatic start_fetch(input logic [PC_W-1:0] p, input logic with_redir);
        @(posedge clka); #1;
        start = 1'b1;
        start_pc = p;
        redirect = with_redir;
        redirect_pc = p ^ 8'h42;
        build(p);
        busy_cyc = 0;
        @(posedge clka); #1;
        start = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic run_to_idle(input string name);
        int c;
        c = 0;
        while (busy && c < 3000) begin
            @(posedge clka); #1;
            c++;
        end
        check({name, "_idle"}, 32'(busy), 32'd0);
        check({name, "_drain"}, 32'(expq.size()), 32'd0);
    endtask

    task automatic wait_pc(input logic [PC_W-1:0] p, output logic found);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (instr_valid && instr_pc == p) found = 1'b1;
            else begin
                @(posedge clka); #1;
            end
        end
        check("reach_pc", 32'(found), 32'd1);
    endtask

    task automatic load_line0();
        for (int l = 0; l < LINES; l++) mem[l] = '0;
        for (int s = 0; s < SLOTS; s++) set_slot(0, s, SLOT_W'(s + 1));
        set_slot(1, 0, HALT_OP);
    endtask

    initial begin
        logic found;
        logic [PC_W-1:0] rpc;
        int nredir;
        logic pend;

        rst = 1'b0; start = 1'b0; redirect = 1'b0; instr_ready = 1'b1;
        start_pc = '0; redirect_pc = '0;
        load_line0();
        #2;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ena", 32'(sram_ena), 32'd0);
        check("rst_addr", 32'(sram_addra), 32'd0);
        check("rst_data", 32'(instr_data), 32'd0);
        check("rst_pc", 32'(instr_pc), 32'd0);
        check("rst_wea", 32'(sram_wea), 32'd0);
        #20 rst = 1'b1;

        // Basic stream across one line boundary into HALT.
        start_fetch(8'h00, 1'b0);
        check("t1_ena", 32'(sram_ena), 32'd1);
        check("t1_addr", 32'(sram_addra), 32'd0);
        check("t1_nvalid", 32'(instr_valid), 32'd0);
        @(posedge clka); #1;
        check("t1_valid", 32'(instr_valid), 32'd1);
        check("t1_data", 32'(instr_data), 32'h001);
        check("t1_pc", 32'(instr_pc), 32'h00);
        run_to_idle("t1");
        check("t1_cycles", 32'(busy_cyc), 32'(exp_busy));

        // Backpressure at pc 2.
        start_fetch(8'h00, 1'b0);
        wait_pc(8'h02, found);
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clka); #1;
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_data", 32'(instr_data), 32'h003);
            check("bp_pc", 32'(instr_pc), 32'h02);
            check("bp_ena", 32'(sram_ena), 32'd0);
        end
        instr_ready = 1'b1;
        run_to_idle("bp");
        check("bp_cycles", 32'(busy_cyc), 32'(exp_busy + 3));

        // Start and redirect together in IDLE: start wins.
        start_fetch(8'h00, 1'b1);
        check("sr_addr", 32'(sram_addra), 32'd0);
        run_to_idle("sr");

        // Wrap from line 31 to line 0.
        set_slot(31, 6, 9'h0A6); set_slot(31, 7, 9'h0A7);
        set_slot(0, 0, 9'h0B0); set_slot(0, 1, HALT_OP);
        start_fetch(8'hFE, 1'b0);
        run_to_idle("wrap");
        check("wrap_cycles", 32'(busy_cyc), 32'(exp_busy));
        check("wrap_last_addr", 32'(sram_addra), 32'd0);

        // HALT mid-line, then restart at 0x10.
        load_line0();
        set_slot(0, 3, HALT_OP);
        set_slot(2, 1, HALT_OP);
        start_fetch(8'h00, 1'b0);
        run_to_idle("halt");
        check("halt_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clka); #1;
            check("halt_ena", 32'(sram_ena), 32'd0);
        end
        start_fetch(8'h10, 1'b0);
        check("restart_addr", 32'(sram_addra), 32'd2);
        run_to_idle("restart");

        // Redirect in IDLE is ignored.
        @(posedge clka); #1;
        redirect = 1'b1; redirect_pc = 8'h42;
        @(posedge clka); #1;
        redirect = 1'b0;
        check("idle_redir_busy", 32'(busy), 32'd0);
        check("idle_redir_ena", 32'(sram_ena), 32'd0);

        // Redirect during backpressure at pc 5.
        load_line0();
        set_slot(8, 2, 9'h0C2); set_slot(8, 3, HALT_OP);
        start_fetch(8'h00, 1'b0);
        wait_pc(8'h05, found);
        instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 8'h42;
        @(posedge clka); #1;
        redirect = 1'b0;
        build(8'h42);
        check("rd_valid", 32'(instr_valid), 32'd0);
        check("rd_ena", 32'(sram_ena), 32'd1);
        check("rd_addr", 32'(sram_addra), 32'd8);
        @(posedge clka); #1;
        check("rd_data", 32'(instr_data), 32'h0C2);
        check("rd_pc", 32'(instr_pc), 32'h42);
        instr_ready = 1'b1;
        run_to_idle("rd");

        // Redirect together with accept at pc 2.
        start_fetch(8'h00, 1'b0);
        wait_pc(8'h02, found);
        redirect = 1'b1; redirect_pc = 8'h42;
        @(posedge clka); #1;
        redirect = 1'b0;
        build(8'h42);
        check("ra_addr", 32'(sram_addra), 32'd8);
        run_to_idle("ra");

        // Redirect while loading.
        start_fetch(8'h00, 1'b0);
        redirect = 1'b1; redirect_pc = 8'h42;
        @(posedge clka); #1;
        redirect = 1'b0;
        build(8'h42);
        check("rl_ena", 32'(sram_ena), 32'd1);
        check("rl_addr", 32'(sram_addra), 32'd8);
        run_to_idle("rl");

        // Async reset mid-ISSUE.
        start_fetch(8'h00, 1'b0);
        wait_pc(8'h03, found);
        #3 rst = 1'b0;
        #1;
        check("ar_valid", 32'(instr_valid), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_ena", 32'(sram_ena), 32'd0);
        expq.delete();
        @(posedge clka); #3 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clka); #1;
            check("ar_quiet_busy", 32'(busy), 32'd0);
            check("ar_quiet_valid", 32'(instr_valid), 32'd0);
        end

        // Randomized programs, ready, redirects and ignored starts.
        for (int it = 0; it < 25; it++) begin
            for (int l = 0; l < LINES; l++)
                for (int s = 0; s < SLOTS; s++)
                    set_slot(l, s, ($urandom_range(0, 19) == 0) ? HALT_OP : SLOT_W'($urandom_range(0, 510)));
            set_slot($urandom_range(0, LINES-1), $urandom_range(0, SLOTS-1), HALT_OP);
            start_fetch(PC_W'($urandom), 1'b0);
            nredir = 0;
            for (int c = 0; c < 3000 && busy; c++) begin
                instr_ready = ($urandom_range(0, 99) < 70);
                pend = 1'b0;
                if (nredir < 3 && $urandom_range(0, 99) < 4) begin
                    rpc = PC_W'($urandom);
                    redirect = 1'b1; redirect_pc = rpc;
                    pend = 1'b1;
                    nredir++;
                end
                if ($urandom_range(0, 99) < 5) begin
                    start = 1'b1; start_pc = PC_W'($urandom);
                end
                @(posedge clka); #1;
                start = 1'b0; redirect = 1'b0;
                if (pend) build(rpc);
            end
            instr_ready = 1'b1;
            run_to_idle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
